tinyenc: RTL and testbench

//  Encrypt side of the 16-bit-half TEA engine: one 32-bit block per req, 16 rounds, one round/clk.

---
 rtl/tinytea_pkg.sv | 48 ++++
 rtl/tinytea_regs.sv | 79 +++++++
 rtl/tinyenc.sv | 97 +++++++++
 tb/tb_tinyenc.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinytea_pkg.sv
// Shared definitions for the 16-bit-half TEA encrypt/decrypt engines:
// config register map, round constants and the round function.
package tinytea_pkg;

   localparam logic [31:0] ADDR_KEY10  = 32'h0000_0000;
   localparam logic [31:0] ADDR_KEY32  = 32'h0000_0004;
   localparam logic [31:0] ADDR_DELTA  = 32'h0000_0008;
   localparam logic [31:0] ADDR_STATUS = 32'h0000_000C;

   localparam logic [4:0] ROUNDS = 5'd16;
   localparam int         SHL    = 4;
   localparam int         SHR    = 5;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_KEY10,
      REG_KEY32,
      REG_DELTA,
      REG_STATUS
   } reg_sel_e;

   // Full 32-bit address match; anything else is unmapped.
   function automatic reg_sel_e addr_decode(input logic [31:0] addr);
      reg_sel_e sel;
      case (addr)
         ADDR_KEY10:  sel = REG_KEY10;
         ADDR_KEY32:  sel = REG_KEY32;
         ADDR_DELTA:  sel = REG_DELTA;
         ADDR_STATUS: sel = REG_STATUS;
         default:     sel = REG_NONE;
      endcase
      return sel;
   endfunction

   function automatic logic [15:0] tea_f(input logic [15:0] v,
                                         input logic [15:0] ka,
                                         input logic [15:0] kb,
                                         input logic [15:0] s);
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
      a = (v << SHL) + ka;
      b = v + s;
      c = (v >> SHR) + kb;
      return a ^ b ^ c;
   endfunction

endpackage

// File: rtl/tinytea_regs.sv
// APB-style config slave: key/delta registers, status readback, and the
// wait-state logic that keeps key/delta frozen while a block is in flight.
module tinytea_regs
   import tinytea_pkg::*;
#(
   parameter logic [63:0] KEY   = 64'h816fc52b09e74da3,
   parameter logic [15:0] DELTA = 16'h9E37
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   input  logic        busy,
   input  logic [15:0] blkcnt,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   output logic [63:0] key,
   output logic [15:0] delta,
   output logic        cfg_commit
);

   reg_sel_e    sel;
   logic        is_cfg;
   logic        setup;
   logic        access;
   logic        cfg_write;
   logic        err;
   logic [31:0] rd_mux;

   always_comb begin
      sel       = addr_decode(paddr);
      is_cfg    = (sel == REG_KEY10) || (sel == REG_KEY32) || (sel == REG_DELTA);
      setup     = psel & ~penable;
      access    = psel & penable;
      cfg_write = access & pwrite & is_cfg;
      pready    = ~(cfg_write & busy);
      cfg_commit = cfg_write & ~busy;
      err       = (sel == REG_NONE) || (pwrite && (sel == REG_STATUS));
      rd_mux    = 32'h0;
      case (sel)
         REG_KEY10:  rd_mux = key[31:0];
         REG_KEY32:  rd_mux = key[63:32];
         REG_DELTA:  rd_mux = {16'h0, delta};
         REG_STATUS: rd_mux = {blkcnt, 15'h0, busy};
         default:    rd_mux = 32'h0;
      endcase
   end

   // Read data and error are captured in the setup cycle so they are stable
   // throughout the access phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key     <= KEY;
         delta   <= DELTA;
         prdata  <= 32'h0;
         pslverr <= 1'b0;
      end else begin
         if (cfg_commit) begin
            case (sel)
               REG_KEY10: key[31:0]  <= pwdata;
               REG_KEY32: key[63:32] <= pwdata;
               REG_DELTA: delta      <= pwdata[15:0];
               default:   ;
            endcase
         end
         if (setup) begin
            pslverr <= err;
            prdata  <= pwrite ? 32'h0 : rd_mux;
         end else if (access && pready) begin
            pslverr <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/tinyenc.sv
// TEA encrypt engine on 16-bit halves: one 32-bit block per request,
// one round per clock, with an APB-style port for key and delta.
module tinyenc
   import tinytea_pkg::*;
#(
   parameter logic [63:0] KEY   = 64'h816fc52b09e74da3,
   parameter logic [15:0] DELTA = 16'h9E37
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic [31:0] rdata,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr
);

   logic [4:0]  rnd_cnt;
   logic [15:0] x_reg;
   logic [15:0] y_reg;
   logic [15:0] sum_reg;
   logic [15:0] blkcnt;
   logic [63:0] key;
   logic [15:0] delta;
   logic        cfg_commit;

   logic [15:0] s_next;
   logic [15:0] x_next;
   logic [15:0] y_next;

   assign ack = (rnd_cnt == 5'd0);

   tinytea_regs #(
      .KEY   (KEY),
      .DELTA (DELTA)
   ) u_regs (
      .clk        (clk),
      .rst        (rst),
      .psel       (psel),
      .penable    (penable),
      .pwrite     (pwrite),
      .paddr      (paddr),
      .pwdata     (pwdata),
      .busy       (~ack),
      .blkcnt     (blkcnt),
      .prdata     (prdata),
      .pready     (pready),
      .pslverr    (pslverr),
      .key        (key),
      .delta      (delta),
      .cfg_commit (cfg_commit)
   );

   // y's half-round uses the freshly updated x within the same clock.
   always_comb begin
      s_next = sum_reg + delta;
      x_next = x_reg + tea_f(y_reg, key[15:0], key[31:16], s_next);
      y_next = y_reg + tea_f(x_next, key[47:32], key[63:48], s_next);
   end

   // A key/delta write completing on the same edge takes priority, so the
   // block always starts with the key that will be used for all its rounds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rnd_cnt <= 5'd0;
         x_reg   <= 16'h0;
         y_reg   <= 16'h0;
         sum_reg <= 16'h0;
         rdata   <= 32'h0;
         blkcnt  <= 16'h0;
      end else if (rnd_cnt == 5'd0) begin
         if (req && !cfg_commit) begin
            rnd_cnt <= ROUNDS;
            x_reg   <= wdata[15:0];
            y_reg   <= wdata[31:16];
            sum_reg <= 16'h0;
         end
      end else begin
         x_reg   <= x_next;
         y_reg   <= y_next;
         sum_reg <= s_next;
         rnd_cnt <= rnd_cnt - 5'd1;
         if (rnd_cnt == 5'd1) begin
            rdata  <= {y_next, x_next};
            blkcnt <= blkcnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_tinyenc.sv
// Scoreboard bench for tinyenc: stimulus pushes expected ciphertexts from a
// plain-arithmetic TEA model; a monitor pops them whenever a block completes.
module tb_tinyenc;

   localparam logic [63:0] DEF_KEY   = 64'h816fc52b09e74da3;
   localparam logic [15:0] DEF_DELTA = 16'h9E37;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic [31:0] wdata = 32'h0;
   logic        ack;
   logic [31:0] rdata;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] paddr = 32'h0;
   logic [31:0] pwdata = 32'h0;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   typedef struct {
      logic [31:0] plain;
      logic [31:0] cipher;
      logic [63:0] key;
      logic [15:0] delta;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   logic [63:0] mKey = DEF_KEY;
   logic [15:0] mDelta = DEF_DELTA;
   int          mBlk = 0;

   tinyenc dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .wdata   (wdata),
      .ack     (ack),
      .rdata   (rdata),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .prdata  (prdata),
      .pready  (pready),
      .pslverr (pslverr)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: TEA on 16-bit halves, written straight from the round rules.
   function automatic logic [15:0] refF(input logic [15:0] v, input logic [15:0] ka,
                                        input logic [15:0] kb, input logic [15:0] s);
      logic [15:0] sh_l, sh_r, vs;
      sh_l = v << 4;
      sh_r = v >> 5;
      vs   = v + s;
      return (sh_l + ka) ^ vs ^ (sh_r + kb);
   endfunction

   function automatic logic [31:0] refEnc(input logic [31:0] pt, input logic [63:0] k,
                                          input logic [15:0] d);
      logic [15:0] x, y, sum;
      x = pt[15:0];
      y = pt[31:16];
      sum = 16'h0;
      for (int r = 0; r < 16; r++) begin
         sum = sum + d;
         x = x + refF(y, k[15:0], k[31:16], sum);
         y = y + refF(x, k[47:32], k[63:48], sum);
      end
      return {y, x};
   endfunction

   function automatic logic [31:0] refDec(input logic [31:0] ct, input logic [63:0] k,
                                          input logic [15:0] d);
      logic [15:0] x, y, sum;
      x = ct[15:0];
      y = ct[31:16];
      sum = 16'(d * 16);
      for (int r = 0; r < 16; r++) begin
         y = y - refF(x, k[47:32], k[63:48], sum);
         x = x - refF(y, k[15:0], k[31:16], sum);
         sum = sum - d;
      end
      return {y, x};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic failTimeout(input string name);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: got timeout expected response", name);
   endtask

   // Monitor: every ack rising edge is a completed block.
   initial begin
      logic prevAck;
      exp_t e;
      prevAck = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            prevAck = 1'b1;
         end else begin
            if (ack && !prevAck) begin
               if (sb.size() == 0) begin
                  failTimeout("unexpected_completion");
               end else begin
                  e = sb.pop_front();
                  checkOutput("cipher", rdata, e.cipher);
                  checkOutput("roundtrip", refDec(rdata, e.key, e.delta), e.plain);
               end
            end
            prevAck = ack;
         end
      end
   end

   task automatic doReset();
      rst = 1'b1;
      req = 1'b0;
      psel = 1'b0;
      penable = 1'b0;
      pwrite = 1'b0;
      sb.delete();
      mKey = DEF_KEY;
      mDelta = DEF_DELTA;
      mBlk = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      @(negedge clk);
      while (!ack && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (!ack) failTimeout("wait_idle");
   endtask

   task automatic pushExpected(input logic [31:0] pt);
      exp_t e;
      e.plain  = pt;
      e.cipher = refEnc(pt, mKey, mDelta);
      e.key    = mKey;
      e.delta  = mDelta;
      sb.push_back(e);
      mBlk++;
   endtask

   // Issue one block; returns at the negedge just after the accept edge.
   task automatic applyStimulus(input logic [31:0] pt);
      waitIdle();
      @(posedge clk);
      #1 req = 1'b1;
      wdata = pt;
      @(posedge clk);
      #1 req = 1'b0;
      wdata = $urandom;
      @(negedge clk);
      checkOutput("accept", {31'h0, ack}, 32'h0);
      pushExpected(pt);
   endtask

   task automatic apbWrite(input logic [31:0] addr, input logic [31:0] data,
                           output logic err, output int waits, output logic ackAtDone);
      @(posedge clk);
      #1 psel = 1'b1;
      penable = 1'b0;
      pwrite = 1'b1;
      paddr = addr;
      pwdata = data;
      @(posedge clk);
      #1 penable = 1'b1;
      waits = 0;
      @(negedge clk);
      while (!pready && waits < 200) begin
         waits++;
         @(negedge clk);
      end
      if (!pready) failTimeout("apb_write_ready");
      err = pslverr;
      ackAtDone = ack;
      @(posedge clk);
      #1 psel = 1'b0;
      penable = 1'b0;
      pwrite = 1'b0;
      case (addr)
         32'h0: mKey[31:0] = data;
         32'h4: mKey[63:32] = data;
         32'h8: mDelta = data[15:0];
         default: ;
      endcase
   endtask

   task automatic apbRead(input logic [31:0] addr, output logic [31:0] data, output logic err);
      int w;
      @(posedge clk);
      #1 psel = 1'b1;
      penable = 1'b0;
      pwrite = 1'b0;
      paddr = addr;
      @(posedge clk);
      #1 penable = 1'b1;
      w = 0;
      @(negedge clk);
      while (!pready && w < 50) begin
         w++;
         @(negedge clk);
      end
      if (!pready) failTimeout("apb_read_ready");
      data = prdata;
      err = pslverr;
      @(posedge clk);
      #1 psel = 1'b0;
      penable = 1'b0;
   endtask

   task automatic readCheck(input string name, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      logic e;
      apbRead(addr, d, e);
      checkOutput(name, d, exp);
      checkOutput({name, "_err"}, {31'h0, e}, 32'h0);
   endtask

   initial begin
      logic        err, ackd;
      int          waits, lowCnt, n;
      int          acceptCyc[3];
      logic [31:0] d, held;

      // Reset values and default register readback
      doReset();
      @(negedge clk);
      checkOutput("rst_ack", {31'h0, ack}, 32'h1);
      checkOutput("rst_rdata", rdata, 32'h0);
      checkOutput("rst_prdata", prdata, 32'h0);
      checkOutput("rst_pready", {31'h0, pready}, 32'h1);
      checkOutput("rst_pslverr", {31'h0, pslverr}, 32'h0);
      readCheck("rd_key10", 32'h0, 32'h09e74da3);
      readCheck("rd_key32", 32'h4, 32'h816fc52b);
      readCheck("rd_delta", 32'h8, 32'h00009E37);
      readCheck("rd_status", 32'hC, 32'h0);

      // Round trip with default key
      applyStimulus(32'h00000000);
      applyStimulus(32'hFFFFFFFF);
      applyStimulus(32'h12345678);
      for (int k = 0; k < 1000; k++) applyStimulus($urandom);
      waitIdle();
      readCheck("status_1003", 32'hC, {16'(mBlk), 16'h0});

      // Zero vector with zero key/delta
      doReset();
      apbWrite(32'h0, 32'h0, err, waits, ackd);
      apbWrite(32'h4, 32'h0, err, waits, ackd);
      apbWrite(32'h8, 32'h0, err, waits, ackd);
      applyStimulus(32'h0);
      lowCnt = 1;
      n = 0;
      @(negedge clk);
      while (!ack && n < 100) begin
         lowCnt++;
         n++;
         @(negedge clk);
      end
      checkOutput("busy_len", lowCnt, 16);
      checkOutput("zero_rdata", rdata, 32'h0);
      readCheck("status_blk1", 32'hC, 32'h00010000);

      // First round visible in the datapath registers
      applyStimulus(32'h00000001);
      @(negedge clk);
      checkOutput("round1", {dut.y_reg, dut.x_reg}, 32'h00110001);
      waitIdle();

      // Delta write while busy stalls until idle; in-flight block keeps old delta
      apbWrite(32'h8, 32'h1234, err, waits, ackd);
      applyStimulus($urandom);
      repeat (3) @(posedge clk);
      apbWrite(32'h8, 32'h9E37, err, waits, ackd);
      checkOutput("wait_states", waits, 11);
      checkOutput("ack_at_ready", {31'h0, ackd}, 32'h1);
      checkOutput("busy_wr_err", {31'h0, err}, 32'h0);
      applyStimulus($urandom);
      waitIdle();
      readCheck("rd_delta_new", 32'h8, 32'h00009E37);

      // req held high: one accept every 17 clocks
      held = $urandom;
      waitIdle();
      @(posedge clk);
      #1 req = 1'b1;
      wdata = held;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         @(negedge clk);
         while (ack && n < 100) begin
            n++;
            @(negedge clk);
         end
         if (ack) failTimeout("held_accept");
         acceptCyc[k] = cyc;
         pushExpected(held);
         if (k == 2) req = 1'b0;
         n = 0;
         while (!ack && n < 100) begin
            n++;
            @(negedge clk);
         end
      end
      checkOutput("held_period1", acceptCyc[1] - acceptCyc[0], 17);
      checkOutput("held_period2", acceptCyc[2] - acceptCyc[1], 17);

      // req and key write completing on the same idle edge: write wins
      waitIdle();
      held = $urandom;
      d = $urandom;
      @(posedge clk);
      #1 psel = 1'b1;
      penable = 1'b0;
      pwrite = 1'b1;
      paddr = 32'h0;
      pwdata = d;
      @(posedge clk);
      #1 penable = 1'b1;
      req = 1'b1;
      wdata = held;
      @(posedge clk);
      #1 psel = 1'b0;
      penable = 1'b0;
      pwrite = 1'b0;
      mKey[31:0] = d;
      @(negedge clk);
      checkOutput("deferred_ack", {31'h0, ack}, 32'h1);
      @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      checkOutput("deferred_accept", {31'h0, ack}, 32'h0);
      pushExpected(held);
      waitIdle();

      // Error responses
      apbRead(32'h10, d, err);
      checkOutput("unmapped_rd_err", {31'h0, err}, 32'h1);
      checkOutput("unmapped_rd_data", d, 32'h0);
      apbWrite(32'h10, 32'hDEADBEEF, err, waits, ackd);
      checkOutput("unmapped_wr_err", {31'h0, err}, 32'h1);
      apbWrite(32'hC, 32'hFFFFFFFF, err, waits, ackd);
      checkOutput("status_wr_err", {31'h0, err}, 32'h1);
      readCheck("rd_delta_kept", 32'h8, 32'h00009E37);

      // Reset in the middle of a block
      applyStimulus($urandom);
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      sb.delete();
      mKey = DEF_KEY;
      mDelta = DEF_DELTA;
      mBlk = 0;
      @(negedge clk);
      checkOutput("midrst_ack", {31'h0, ack}, 32'h1);
      checkOutput("midrst_rdata", rdata, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      readCheck("midrst_key10", 32'h0, 32'h09e74da3);
      readCheck("midrst_key32", 32'h4, 32'h816fc52b);
      readCheck("midrst_delta", 32'h8, 32'h00009E37);
      readCheck("midrst_status", 32'hC, 32'h0);

      repeat (3) @(negedge clk);
      checkOutput("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
